// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes and FSM states.
// Divide support is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_signed_op(input logic [2:0] op_code);
        return (op_code == OP_MULT) || (op_code == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_q
);

    // Multiply: accumulator top bit is always zero, so the add cannot overflow WIDTH+1 bits.
    logic [WIDTH:0] w_sum;
    assign w_sum = i_q[0] ? (i_rem + {1'b0, i_operand}) : i_rem;

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    assign w_shift = {i_rem[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_operand};

    // A set top bit on the difference means the trial subtract borrowed: restore.
    always_comb begin
        o_rem = {1'b0, w_sum[WIDTH:1]};
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        if (i_div) begin
            if (!w_diff[WIDTH]) begin
                o_rem = w_diff;
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end else begin
                o_rem = w_shift;
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    logic w_unused_div;
    assign w_unused_div = i_div;
    assign o_rem = {1'b0, w_sum[WIDTH:1]};
    assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU act as no-ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_t           o_dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
`ifdef MULDIV_DIV_EN
    logic             r_is_div;
    logic             r_neg_r;
`endif

    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_step_div;
    logic [WIDTH:0]   w_step_rem;
    logic [WIDTH-1:0] w_step_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_sign_a = is_signed_op(op) & a[WIDTH-1];
    assign w_sign_b = is_signed_op(op) & b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -a : a;
    assign w_mag_b  = w_sign_b ? -b : b;

`ifdef MULDIV_DIV_EN
    assign w_step_div = r_is_div;
`else
    assign w_step_div = 1'b0;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div     (w_step_div),
        .i_rem     (r_rem),
        .i_q       (r_q),
        .i_operand (r_opnd),
        .o_rem     (w_step_rem),
        .o_q       (w_step_q)
    );

    assign w_prod     = {r_rem[WIDTH-1:0], r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_remd;
    // Truncating division: quotient sign from the operand XOR, remainder follows the dividend.
    assign w_quo  = r_neg_q ? -r_q : r_q;
    assign w_remd = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_opnd     <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_r    <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                // DONE accepts a new request exactly like IDLE for back-to-back issue.
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_rem   <= '0;
                                r_q     <= w_mag_b;
                                r_opnd  <= w_mag_a;
                                r_neg_q <= w_sign_a ^ w_sign_b;
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                                r_state <= ST_CALC;
`ifdef MULDIV_DIV_EN
                                r_is_div <= 1'b0;
`endif
                            end
`ifdef MULDIV_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                if (b == '0) begin
                                    r_done     <= 1'b1;
                                    r_div_zero <= 1'b1;
                                    r_state    <= ST_DONE;
                                end else begin
                                    r_rem    <= '0;
                                    r_q      <= w_mag_a;
                                    r_opnd   <= w_mag_b;
                                    r_neg_q  <= w_sign_a ^ w_sign_b;
                                    r_neg_r  <= w_sign_a;
                                    r_is_div <= 1'b1;
                                    r_cnt    <= '0;
                                    r_busy   <= 1'b1;
                                    r_state  <= ST_CALC;
                                end
                            end
`endif
                            OP_MTHI: begin
                                r_hi    <= a;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                            OP_MTLO: begin
                                r_lo    <= a;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                            default: begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    r_rem <= w_step_rem;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
`ifdef MULDIV_DIV_EN
                    if (r_is_div) begin
                        r_hi <= w_remd;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
`else
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
`endif
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_zero    = r_div_zero;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32; DIV expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int LONG_CYC = W + 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  state_t       dbg_state;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .hi          (hi),
    .lo          (lo),
    .o_dbg_state (dbg_state)
  );

  // Scoreboard
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] xa,
                                           input logic [W-1:0] xb, input logic [W-1:0] h,
                                           input logic [W-1:0] l);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     q64, r64;
    logic [2*W-1:0]  r;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    ua = {32'd0, xa};
    ub = {32'd0, xb};
    r = {h, l};
    case (o)
      3'd0: begin q64 = sa * sb; r = q64; end
      3'd1: begin q64 = ua * ub; r = q64; end
`ifdef MULDIV_DIV_EN
      3'd2: if (xb != '0) begin q64 = sa / sb; r64 = sa % sb; r = {r64[31:0], q64[31:0]}; end
      3'd3: if (xb != '0) begin q64 = ua / ub; r64 = ua % ub; r = {r64[31:0], q64[31:0]}; end
`endif
      3'd4: r = {xa, l};
      3'd5: r = {h, xa};
      default: r = {h, l};
    endcase
    return r;
  endfunction

  function automatic int exp_cycles(input logic [2:0] o, input logic [W-1:0] xb);
    if (o == 3'd0 || o == 3'd1) return LONG_CYC;
`ifdef MULDIV_DIV_EN
    if ((o == 3'd2 || o == 3'd3) && xb != '0) return LONG_CYC;
`endif
    return 0;
  endfunction

  function automatic logic exp_dz(input logic [2:0] o, input logic [W-1:0] xb);
`ifdef MULDIV_DIV_EN
    return (o == 3'd2 || o == 3'd3) && xb == '0;
`else
    return 1'b0 & (o[0] ^ xb[0]);
`endif
  endfunction

  // Driver tasks
  task automatic wait_done(output int cyc, output int bcnt, output logic dz, output bit tmo);
    cyc = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (busy === 1'b1) bcnt++;
    dz = div_zero;
    tmo = (done !== 1'b1);
  endtask

  task automatic push_exp(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    logic [2*W-1:0] e;
    e = model(o, xa, xb, m_hi, m_lo);
    exp_q.push_back(e);
    m_hi = e[2*W-1:W];
    m_lo = e[W-1:0];
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       output int cyc, output int bcnt, output logic dz, output bit tmo);
    push_exp(o, xa, xb);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(cyc, bcnt, dz, tmo);
  endtask

  task automatic test_reset;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    n_tests++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
  endtask

  task automatic test_mult;
    int cyc, bcnt; logic dz; bit tmo; logic [2*W-1:0] e;
    do_op(OP_MULT, 32'hFFFFFFFE, 32'd3, cyc, bcnt, dz, tmo);
    e = exp_q.pop_front();
    n_tests++; if (tmo) begin n_fail++; $display("FAIL mult_timeout got=no_done exp=done"); end
    n_tests++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL mult_result got=%h exp=%h", {hi, lo}, e); end
    n_tests++; if (e !== 64'hFFFFFFFF_FFFFFFFA) begin n_fail++; $display("FAIL mult_model got=%h exp=FFFFFFFFFFFFFFFA", e); end
    n_tests++; if (cyc !== LONG_CYC) begin n_fail++; $display("FAIL mult_latency got=%0d exp=%0d", cyc, LONG_CYC); end
    n_tests++; if (bcnt !== LONG_CYC) begin n_fail++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", bcnt, LONG_CYC); end
    n_tests++; if (dz !== 1'b0) begin n_fail++; $display("FAIL mult_dz got=%b exp=0", dz); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bcnt, dz, tmo);
    e = exp_q.pop_front();
    n_tests++; if ({hi, lo} !== 64'hFFFFFFFE_00000001 || {hi, lo} !== e) begin
      n_fail++; $display("FAIL multu_result got=%h exp=%h", {hi, lo}, e);
    end
  endtask

  task automatic test_div;
    logic [W-1:0] da [3] = '{32'hFFFFFFF9, 32'h80000000, 32'd100};
    logic [W-1:0] db [3] = '{32'd2, 32'hFFFFFFFF, 32'd7};
    logic [2:0]   dop[3] = '{OP_DIV, OP_DIV, OP_DIVU};
    int cyc, bcnt; logic dz; bit tmo; logic [2*W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      do_op(dop[i], da[i], db[i], cyc, bcnt, dz, tmo);
      e = exp_q.pop_front();
      n_tests++; if (tmo) begin n_fail++; $display("FAIL div%0d_timeout got=no_done exp=done", i); end
      n_tests++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL div%0d_result got=%h exp=%h", i, {hi, lo}, e); end
      n_tests++; if (cyc !== exp_cycles(dop[i], db[i])) begin
        n_fail++; $display("FAIL div%0d_latency got=%0d exp=%0d", i, cyc, exp_cycles(dop[i], db[i]));
      end
    end
`ifdef MULDIV_DIV_EN
    n_tests++; if ({hi, lo} !== 64'h00000002_0000000E) begin n_fail++; $display("FAIL divu_100_7 got=%h exp=2_E", {hi, lo}); end
`endif
  endtask

  task automatic test_div_zero;
    int cyc, bcnt; logic dz; bit tmo; logic [2*W-1:0] e;
    do_op(OP_MTHI, 32'h12345678, 32'd0, cyc, bcnt, dz, tmo);
    e = exp_q.pop_front();
    n_tests++; if ({hi, lo} !== e || cyc !== 0) begin n_fail++; $display("FAIL mthi got=%h/%0d exp=%h/0", {hi, lo}, cyc, e); end
    n_tests++; if (bcnt !== 0) begin n_fail++; $display("FAIL mthi_busy got=%0d exp=0", bcnt); end
    do_op(OP_DIVU, 32'd55, 32'd0, cyc, bcnt, dz, tmo);
    e = exp_q.pop_front();
    n_tests++; if (cyc !== 0 || tmo) begin n_fail++; $display("FAIL divz_latency got=%0d exp=0", cyc); end
    n_tests++; if (dz !== exp_dz(OP_DIVU, 32'd0)) begin n_fail++; $display("FAIL divz_flag got=%b exp=%b", dz, exp_dz(OP_DIVU, 32'd0)); end
    n_tests++; if (hi !== 32'h12345678 || {hi, lo} !== e) begin n_fail++; $display("FAIL divz_hold got=%h exp=%h", {hi, lo}, e); end
    n_tests++; if (bcnt !== 0) begin n_fail++; $display("FAIL divz_busy got=%0d exp=0", bcnt); end
    @(negedge clk);
    n_tests++; if (div_zero !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL divz_pulse got=%b%b exp=00", done, div_zero); end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt; logic dz; bit tmo; logic [2*W-1:0] e;
    push_exp(OP_MULTU, 32'h1234, 32'h10);
    @(negedge clk); start = 1'b1; op = OP_MULTU; a = 32'h1234; b = 32'h10;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'hDEAD;
    @(negedge clk); start = 1'b0;
    wait_done(cyc, bcnt, dz, tmo);
    e = exp_q.pop_front();
    n_tests++; if (tmo || {hi, lo} !== e) begin n_fail++; $display("FAIL ignore_start got=%h exp=%h", {hi, lo}, e); end
    push_exp(OP_MULTU, 32'h0001_0001, 32'hFFFF);
    start = 1'b1; op = OP_MULTU; a = 32'h0001_0001; b = 32'hFFFF;
    @(negedge clk); start = 1'b0; a = '0; b = '0;
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got=busy%b_done%b exp=busy1_done0", busy, done); end
    wait_done(cyc, bcnt, dz, tmo);
    e = exp_q.pop_front();
    n_tests++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL b2b_result got=%h exp=%h", {hi, lo}, e); end
    n_tests++; if (cyc !== LONG_CYC) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, LONG_CYC); end
  endtask

  task automatic test_random;
    int cyc, bcnt; logic dz; bit tmo; logic [2*W-1:0] e;
    logic [2:0] o; logic [W-1:0] xa, xb;
    for (int i = 0; i < 12; i++) begin
      o  = 3'($urandom_range(0, 7));
      xa = $urandom;
      xb = ($urandom_range(0, 3) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      do_op(o, xa, xb, cyc, bcnt, dz, tmo);
      e = exp_q.pop_front();
      n_tests++; if (tmo || {hi, lo} !== e) begin n_fail++; $display("FAIL rand%0d_op%0d got=%h exp=%h", i, o, {hi, lo}, e); end
      n_tests++; if (cyc !== exp_cycles(o, xb) || dz !== exp_dz(o, xb)) begin
        n_fail++; $display("FAIL rand%0d_timing got=%0d/%b exp=%0d/%b", i, cyc, dz, exp_cycles(o, xb), exp_dz(o, xb));
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bcnt; logic dz; bit tmo; logic [2*W-1:0] e;
    @(negedge clk); start = 1'b1; op = OP_MULT; a = 32'h7654321; b = 32'h13579;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++; if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got=%b exp=000", {busy, done, div_zero}); end
    n_tests++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL midrst_hilo got=%h exp=0", {hi, lo}); end
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst = 1'b1;
    do_op(OP_DIVU, 32'd100, 32'd7, cyc, bcnt, dz, tmo);
    e = exp_q.pop_front();
    n_tests++; if (tmo || {hi, lo} !== e) begin n_fail++; $display("FAIL post_rst_divu got=%h exp=%h", {hi, lo}, e); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
